simplez_uart_tx: RTL and testbench
==================================

Name: simplez_uart_tx

Overview:
- Memory-mapped serial output peripheral for the Simplez CPU. It sits directly downstream of the CPU data/address bus.
- The CPU writes a character word to the data address. The block holds it in a 1-deep holding register and serializes the low 8 bits as 8N1 on `tx`.
- The CPU polls the status address for ready/busy/overflow.
- It replaces the 4-bit LED output as the program-visible output channel on the board.

Parameters:
- BAUD_DIV, 104: clock cycles per serial bit (12 MHz / 115200). Legal range 2..4095.
- ADDR_DATA, 9'd508: write address of the TX data register.
- ADDR_STATUS, 9'd509: read address of the status register.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- addr, input, 9: CPU address bus.
- din, input, 12: CPU write data; bits [7:0] are transmitted, [11:8] are ignored.
- wr, input, 1: CPU write strobe, one cycle per access.
- rd, input, 1: CPU read strobe, one cycle per access.
- dout, output, 12: read data. Status word when addr==ADDR_STATUS, else 0 (combinational).
- tx, output, 1: serial line, idle high, registered.
- irq_ready, output, 1: high while the holding register is empty.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at a clk edge):
  - tx=1, state=IDLE, hold_full=0, ovf=0, baud counter=0, shifter=0, bit index=0.
  - Hence irq_ready=1 and status word = 12'h001.
  - Reset mid-frame aborts the frame immediately: tx returns to 1 on that same edge. No partial bits resume.
- Status word: bit0 ready (=~hold_full), bit1 busy (state!=IDLE), bit2 ovf, bits[11:3]=0.
- Write: wr && addr==ADDR_DATA at an edge.
  - If hold_full=0: hold<=din[7:0], hold_full<=1.
  - If hold_full=1: data is dropped, hold is unchanged, ovf<=1 (sticky).
- ovf clear: rd && addr==ADDR_STATUS clears ovf at that edge. If an overflow write occurs on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when hold_full=1 at an edge, load shifter<=hold, hold_full<=0, tx<=0, counter<=0, go to START.
  - A write landing on that same loading edge refills hold with the new data (hold_full stays 1). No ovf.
  - START: after BAUD_DIV cycles, tx<=shifter[0], bit index<=0, go to DATA.
  - DATA: every BAUD_DIV cycles, shift right and output the next bit, LSB first. After bit 7 has been held BAUD_DIV cycles, tx<=1, go to STOP.
  - STOP: after BAUD_DIV cycles, go to IDLE.
    - If hold_full=1 on that edge, go directly to START instead: tx<=0, load shifter. This gives back-to-back frames with no idle gap.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and emits a tick on BAUD_DIV-1, then wraps to 0.
  - Cleared on every frame load.
  - Held at 0 in IDLE.
- Latency: write sampled at edge k → tx falls at edge k+1 (if idle).
- Frame length: exactly 10*BAUD_DIV cycles from tx falling to the earliest next-frame start bit.
- Throughput: one queued character can be accepted while a frame is in flight. ready re-asserts on the edge hold transfers to the shifter.
- Writes to any other address, and reads with rd to other addresses, have no effect.
- wr and rd never assert together (CPU guarantee). If they do, both actions apply.

Decomposition:
- Shared package simplez_pkg:
  - WORD_W=12, ADDR_W=9, default ADDR_DATA/ADDR_STATUS constants.
  - Status bit index constants (ST_READY=0, ST_BUSY=1, ST_OVF=2).
  - TX state enum {IDLE, START, DATA, STOP}.
- Sub-module simplez_baud_gen:
  - Parameter BAUD_DIV; inputs clk, rst, clear, en; output tick.
  - Reused later by the matching receiver.

Test Plan (BAUD_DIV=4 for all):
- Reset: rst high 2 cycles then low → tx=1, dout at ADDR_STATUS = 12'h001, irq_ready=1.
- Single char: write 12'hF41 at ADDR_DATA at edge k → tx=0 on edges k+1..k+4. Data bits 1,0,0,0,0,0,1,0 follow, each 4 cycles. tx=1 stop bit from edge k+37 for 4 cycles, busy drops at edge k+41. Bits [11:8] have no effect.
- Back-to-back: write 8'h55, then write 8'hAA while 8'h55 is in DATA → ready goes 0 then 1 when 8'hAA loads. The second start bit begins exactly 40 cycles after the first; no idle gap.
- Overflow: write 8'h01, 8'h02, 8'h03 on consecutive cycles → 8'h01 and 8'h02 are transmitted, 8'h03 is dropped. Status reads 12'h006 mid-frame. rd of status clears ovf, next read gives 12'h002.
- Simultaneous set/clear: rd status and overflowing write on the same edge → ovf remains 1.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 on that edge, status 12'h001. A new write afterwards produces a clean full frame.

Source files
------------

// File: rtl/simplez_pkg.sv
// Shared constants and types for the Simplez memory-mapped peripherals.
// Bus widths, default register addresses, status bit positions and TX FSM states.
package simplez_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] ADDR_DATA_DEF   = 9'd508;
  localparam logic [ADDR_W-1:0] ADDR_STATUS_DEF = 9'd509;

  localparam int ST_READY = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/simplez_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and pulses tick on the last count.
// Shared by the Simplez UART transmitter and receiver.
module simplez_baud_gen #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Disabled means parked at zero, so the first period after enable is full length.
  always_comb begin
    if (clear || !en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter for the Simplez CPU with a 1-deep holding
// register, a sticky overflow flag and a polled status word.
module simplez_uart_tx
  import simplez_pkg::*;
#(
  parameter int                BAUD_DIV    = 104,
  parameter logic [ADDR_W-1:0] ADDR_DATA   = ADDR_DATA_DEF,
  parameter logic [ADDR_W-1:0] ADDR_STATUS = ADDR_STATUS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  input  logic              wr,
  input  logic              rd,
  output logic [WORD_W-1:0] dout,
  output logic              tx,
  output logic              irq_ready
);

  tx_state_e   state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  shifter_q, shifter_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;

  logic        wr_data;
  logic        rd_status;
  logic        load;
  logic        baud_tick;
  logic        unused_din_hi;

  assign wr_data       = wr && (addr == ADDR_DATA);
  assign rd_status     = rd && (addr == ADDR_STATUS);
  assign unused_din_hi = ^din[WORD_W-1:8];

  simplez_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(load),
    .en   (state_q != IDLE),
    .tick (baud_tick)
  );

  // NOTE: every signal assigned here gets its default first so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    shifter_d   = shifter_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d      = shifter_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shifter_d = shifter_q >> 1;
            tx_d      = shifter_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (hold_full_q) begin
            load    = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shifter_d   = hold_q;
      hold_full_d = 1'b0;
    end

    // Clear first so a same-edge overflow write leaves ovf set.
    if (rd_status) begin
      ovf_d = 1'b0;
    end

    // A write on the transfer edge refills the register being emptied.
    if (wr_data) begin
      if (!hold_full_q || load) begin
        hold_d      = din[7:0];
        hold_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      shifter_q   <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      shifter_q   <= shifter_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    dout = '0;
    if (addr == ADDR_STATUS) begin
      dout[ST_READY] = ~hold_full_q;
      dout[ST_BUSY]  = (state_q != IDLE);
      dout[ST_OVF]   = ovf_q;
    end
  end

  assign tx        = tx_q;
  assign irq_ready = ~hold_full_q;

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Self-checking bench for simplez_uart_tx (BAUD_DIV=4): directed CPU accesses plus a
// line monitor that decodes each 8N1 frame and checks it against a scoreboard queue.
module tb_simplez_uart_tx;

  localparam int         BD     = 4;
  localparam logic [8:0] A_DATA = 9'd508;
  localparam logic [8:0] A_STAT = 9'd509;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  addr;
  logic [11:0] din;
  logic        wr;
  logic        rd;
  logic [11:0] dout;
  logic        tx;
  logic        irq_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  simplez_uart_tx #(
    .BAUD_DIV   (BD),
    .ADDR_DATA  (A_DATA),
    .ADDR_STATUS(A_STAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .din      (din),
    .wr       (wr),
    .rd       (rd),
    .dout     (dout),
    .tx       (tx),
    .irq_ready(irq_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [11:0] v);
    addr = A_DATA;
    din  = v;
    wr   = 1'b1;
    step(1);
    wr   = 1'b0;
    addr = '0;
  endtask

  task automatic status_is(input string name, input logic [11:0] exp);
    addr = A_STAT;
    #1;
    check(name, dout, exp);
    addr = '0;
  endtask

  task automatic read_status();
    addr = A_STAT;
    rd   = 1'b1;
    step(1);
    rd   = 1'b0;
    addr = '0;
  endtask

  // Line monitor: sample each bit mid-period, pop the expected byte at the stop bit.
  initial begin
    int         n;
    bit         in_frame;
    logic [7:0] sh;
    logic [7:0] e;
    in_frame = 1'b0;
    n        = 0;
    sh       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          n        = 0;
          start_q.push_back(cyc);
        end
      end else begin
        n++;
        if (n == 2) begin
          check("mon_start_bit", tx, 1'b0);
        end else if (n >= 6 && n <= 34 && ((n - 2) % BD) == 0) begin
          sh = {tx, sh[7:1]};
        end else if (n == 38) begin
          check("mon_stop_bit", tx, 1'b1);
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected_frame: got %0h expected none", sh);
          end else begin
            e = exp_q.pop_front();
            check("mon_frame_data", sh, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] ch;
    logic       exp_tx;
    rst  = 1'b1;
    addr = '0;
    din  = '0;
    wr   = 1'b0;
    rd   = 1'b0;

    // Reset state
    step(2);
    rst = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_irq_ready", irq_ready, 1'b1);
    status_is("reset_status", 12'h001);
    addr = A_DATA;
    #1;
    check("dout_other_addr", dout, 12'h000);
    addr = '0;

    // Write to the status address is ignored
    addr = A_STAT;
    din  = 12'h077;
    wr   = 1'b1;
    step(1);
    wr   = 1'b0;
    addr = '0;
    check("wr_other_addr_tx", tx, 1'b1);
    status_is("wr_other_addr_status", 12'h001);
    step(2);

    // Single character: full waveform against the 8N1 timing model
    ch = 8'h41;
    exp_q.push_back(ch);
    write_word(12'hF41);
    check("single_tx_at_k", tx, 1'b1);
    for (int j = 1; j <= 44; j++) begin
      step(1);
      if (j <= 4)       exp_tx = 1'b0;
      else if (j <= 36) exp_tx = ch[(j - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("single_tx_k+%0d", j), tx, exp_tx);
      status_is($sformatf("single_status_k+%0d", j), (j <= 40) ? 12'h003 : 12'h001);
    end
    step(3);

    // Back-to-back frames with one character queued
    start_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    write_word(12'h055);
    step(1);
    check("b2b_ready_after_load", irq_ready, 1'b1);
    step(8);
    write_word(12'h0AA);
    check("b2b_ready_low", irq_ready, 1'b0);
    step(30);
    check("b2b_ready_still_low", irq_ready, 1'b0);
    step(1);
    check("b2b_ready_reassert", irq_ready, 1'b1);
    step(48);
    check("b2b_frame_count", start_q.size(), 2);
    if (start_q.size() == 2)
      check("b2b_start_spacing", start_q[1] - start_q[0], 40);

    // Overflow: third consecutive write is dropped
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    addr = A_DATA;
    wr   = 1'b1;
    din  = 12'h001;
    step(1);
    din  = 12'h002;
    step(1);
    din  = 12'h003;
    step(1);
    wr   = 1'b0;
    addr = '0;
    status_is("ovf_status_set", 12'h006);
    step(3);
    status_is("ovf_status_sticky", 12'h006);
    read_status();
    status_is("ovf_status_cleared", 12'h002);
    step(90);
    status_is("ovf_idle_status", 12'h001);

    // Overflowing write with rd strobe at the data address still sets ovf
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    write_word(12'h010);
    step(1);
    write_word(12'h020);
    addr = A_DATA;
    din  = 12'h030;
    wr   = 1'b1;
    rd   = 1'b1;
    step(1);
    wr   = 1'b0;
    rd   = 1'b0;
    addr = '0;
    status_is("wr_rd_ovf_set", 12'h006);
    read_status();
    status_is("wr_rd_ovf_cleared", 12'h002);
    step(90);

    // Reset mid-frame during data bit 3, then a clean frame
    write_word(12'h03C);
    step(18);
    rst = 1'b1;
    step(1);
    check("midrst_tx", tx, 1'b1);
    check("midrst_irq_ready", irq_ready, 1'b1);
    status_is("midrst_status", 12'h001);
    rst = 1'b0;
    step(2);
    exp_q.push_back(8'hA5);
    write_word(12'h0A5);
    step(1);
    check("post_rst_start", tx, 1'b0);
    step(45);
    status_is("post_rst_idle", 12'h001);

    check("all_frames_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
